// File: rtl/reg_bank_wb.sv
// 32x32 register bank with a one-entry write-back stage and commit counter.
// Optional read forwarding from the write stage: define REG_BANK_BYPASS_EN.
module reg_bank_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] write_reg_data,
  input  logic        stall,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        wb_pending,
  output logic        hazard,
  output logic [15:0] wr_count
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        stage_valid_q, stage_valid_d;
  logic [4:0]  stage_addr_q,  stage_addr_d;
  logic [31:0] stage_data_q,  stage_data_d;
  logic [15:0] wr_count_q,    wr_count_d;

  logic [31:0] rs_arr, rt_arr;
  logic        rs_hit, rt_hit;

  always_comb begin
    regs_d        = regs_q;
    stage_valid_d = stage_valid_q;
    stage_addr_d  = stage_addr_q;
    stage_data_d  = stage_data_q;
    wr_count_d    = wr_count_q;
    // Stall freezes stage and array; any write offered meanwhile is dropped.
    if (!stall) begin
      if (stage_valid_q && (stage_addr_q != 5'd0)) begin
        regs_d[stage_addr_q] = stage_data_q;
        wr_count_d           = wr_count_q + 16'd1;
      end
      stage_valid_d = wr_en && (wr_addr != 5'd0);
      stage_addr_d  = wr_addr;
      stage_data_d  = write_reg_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q        <= '{default: '0};
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
      wr_count_q    <= '0;
    end else begin
      regs_q        <= regs_d;
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
      wr_count_q    <= wr_count_d;
    end
  end

  always_comb begin
    rs_arr = (rs_addr == 5'd0) ? '0 : regs_q[rs_addr];
    rt_arr = (rt_addr == 5'd0) ? '0 : regs_q[rt_addr];
    rs_hit = stage_valid_q && (stage_addr_q == rs_addr);
    rt_hit = stage_valid_q && (stage_addr_q == rt_addr);
  end

  always_comb begin
    rs_data    = '0;
    rt_data    = '0;
    hazard     = 1'b0;
    wb_pending = 1'b0;
    wr_count   = '0;
    if (rst) begin
`ifdef REG_BANK_BYPASS_EN
      rs_data = rs_hit ? stage_data_q : rs_arr;
      rt_data = rt_hit ? stage_data_q : rt_arr;
      hazard  = 1'b0;
`else
      rs_data = rs_arr;
      rt_data = rt_arr;
      hazard  = rs_hit || rt_hit;
`endif
      wb_pending = stage_valid_q;
      wr_count   = wr_count_q;
    end
  end

endmodule
